// File: rtl/arith_unit_seq.sv
// Sequential unsigned arithmetic unit: single-cycle add/sub, iterative shift-add
// multiply and restoring divide, with a start/busy/done handshake.
module arith_unit_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     select,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [2*N-1:0] result
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           is_div;
  logic [N-1:0]   opa;
  logic [N-1:0]   opb;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_next;
  logic [N:0]     add_full;
  logic [N:0]     sub_full;

  // acc = {partial_hi, multiplier}; shift right, adding the multiplicand when lsb is set
  function automatic logic [2*N-1:0] mul_step(input logic [2*N-1:0] p,
                                              input logic [N-1:0]   a);
    logic [N:0] s;
    s = {1'b0, p[2*N-1:N]} + (p[0] ? {1'b0, a} : '0);
    return {s, p[N-1:1]};
  endfunction

  // acc = {remainder, dividend/quotient}; a zero divisor naturally yields q=all ones, r=x
  function automatic logic [2*N-1:0] div_step(input logic [2*N-1:0] p,
                                              input logic [N-1:0]   d);
    logic [N:0]   r;
    logic [N-1:0] t;
    r = {p[2*N-1:N], p[N-1]};
    if (r >= {1'b0, d}) begin
      t = r[N-1:0] - d;
      return {t, p[N-2:0], 1'b1};
    end
    return {r[N-1:0], p[N-2:0], 1'b0};
  endfunction

  always_comb begin
    add_full = {1'b0, x} + {1'b0, y};
    sub_full = {1'b0, x} - {1'b0, y};
    acc_next = is_div ? div_step(acc, opb) : mul_step(acc, opa);
  end

  // Datapath registers: operands latched at start, accumulator iterates in RUN
  always_ff @(posedge clk) begin
    if (state == IDLE && start && select[1]) begin
      is_div <= select[0];
      opa    <= x;
      opb    <= y;
      acc    <= select[0] ? {{N{1'b0}}, x} : {{N{1'b0}}, y};
    end else if (state == RUN) begin
      acc <= acc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            if (!select[1]) begin
              state  <= DONE;
              done   <= 1'b1;
              err    <= 1'b0;
              result <= select[0] ? {{(N-1){1'b0}}, sub_full}
                                  : {{(N-1){1'b0}}, add_full};
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= acc_next;
            err    <= is_div && (opb == '0);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_unit_seq.sv
// Directed bench for arith_unit_seq with N=4 and hand-computed expected values.
module tb_arith_unit_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] select;
  logic [3:0] x;
  logic [3:0] y;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] result;

  int nchk;
  int nerr;

  arith_unit_seq #(.N(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .select (select),
    .x      (x),
    .y      (y),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] s, input logic [3:0] a,
                        input logic [3:0] b, input logic [7:0] er, input logic ee,
                        input int lat);
    int n;
    select = s; x = a; y = b; start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_res"}, result, er);
    chk({tag, "_err"}, err, ee);
    step();
    chk({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int seen;
    logic [7:0] exp_sum;
    nchk = 0;
    nerr = 0;

    // reset held two cycles with start asserted and random operands
    reset = 1'b1; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      select = 2'($urandom); x = 4'($urandom); y = 4'($urandom);
      step();
      chk("rst_state", {busy, done, err, result}, 11'h000);
    end
    reset = 1'b0; start = 1'b0;
    step();

    // add: done in c+1
    select = 2'd0; x = 4'd9; y = 4'd8; start = 1'b1;
    step();
    start = 1'b0;
    chk("add_hs", {busy, done}, 2'b11);
    chk("add_res", result, 8'h11);
    chk("add_err", err, 1'b0);
    step();
    chk("add_idle", {busy, done}, 2'b00);

    run_op("sub", 2'd1, 4'd3, 4'd5, 8'h1E, 1'b0, 1);

    // mul 15*15 with operands disturbed during RUN
    select = 2'd2; x = 4'd15; y = 4'd15; start = 1'b1;
    step();
    start = 1'b0;
    chk("mul_c1", {busy, done}, 2'b10);
    select = 2'd1; x = 4'd0; y = 4'd0;
    for (int k = 2; k <= 4; k++) begin
      step();
      chk("mul_run", {busy, done}, 2'b10);
    end
    step();
    chk("mul_c5", {busy, done}, 2'b11);
    chk("mul_res", result, 8'hE1);
    step();
    chk("mul_idle", {busy, done}, 2'b00);

    run_op("div", 2'd3, 4'd13, 4'd4, 8'h13, 1'b0, 5);
    run_op("div0", 2'd3, 4'd7, 4'd0, 8'h7F, 1'b1, 5);
    run_op("add11", 2'd0, 4'd1, 4'd1, 8'h02, 1'b0, 1);

    // reset during mul 6*7 aborts the operation
    select = 2'd2; x = 4'd6; y = 4'd7; start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_state", {busy, done, err, result}, 11'h000);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done) seen++;
    end
    chk("abort_nodone", seen, 0);

    // start pulse during DONE of a mul is ignored
    select = 2'd2; x = 4'd2; y = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 2; k <= 5; k++) step();
    chk("mul23_done", done, 1'b1);
    chk("mul23_res", result, 8'h06);
    select = 2'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_idle", {busy, done}, 2'b00);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done) seen++;
    end
    chk("ign_nodone", seen, 0);

    // start held high: an add completes every 2 cycles
    select = 2'd0; x = 4'd5; y = 4'd6; start = 1'b1;
    exp_sum = 8'h0B;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i % 2 == 0) begin
        chk("b2b_done", {busy, done}, 2'b11);
        chk("b2b_res", result, exp_sum);
        x = x + 4'd3;
        exp_sum = 8'({1'b0, x} + {1'b0, y});
      end else begin
        chk("b2b_gap", {busy, done}, 2'b00);
      end
    end
    start = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
